// File: rtl/wb_interconnect_nxm.sv
// N-master x M-slave Wishbone crossbar: per-target round-robin arbiters with CYC-long
// ownership, address decode with an internal error target, and a per-target watchdog.
module wb_interconnect_nxm #(
   parameter int N_MASTERS = 3,
   parameter int N_SLAVES = 2,
   parameter int WB_ADDR_WIDTH = 32,
   parameter int WB_DATA_WIDTH = 32,
   parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_BASE = '0,
   parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_LIMIT = '0,
   parameter int TIMEOUT = 256
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]   m_ADR,
   input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]   m_DAT_W,
   input  logic [N_MASTERS*WB_DATA_WIDTH/8-1:0] m_SEL,
   input  logic [N_MASTERS*3-1:0]               m_CTI,
   input  logic [N_MASTERS*2-1:0]               m_BTE,
   input  logic [N_MASTERS-1:0]                 m_CYC,
   input  logic [N_MASTERS-1:0]                 m_STB,
   input  logic [N_MASTERS-1:0]                 m_WE,
   output logic [N_MASTERS*WB_DATA_WIDTH-1:0]   m_DAT_R,
   output logic [N_MASTERS-1:0]                 m_ACK,
   output logic [N_MASTERS-1:0]                 m_ERR,
   output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]    s_ADR,
   output logic [N_SLAVES*WB_DATA_WIDTH-1:0]    s_DAT_W,
   output logic [N_SLAVES*WB_DATA_WIDTH/8-1:0]  s_SEL,
   output logic [N_SLAVES*3-1:0]                s_CTI,
   output logic [N_SLAVES*2-1:0]                s_BTE,
   output logic [N_SLAVES-1:0]                  s_CYC,
   output logic [N_SLAVES-1:0]                  s_STB,
   output logic [N_SLAVES-1:0]                  s_WE,
   input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]    s_DAT_R,
   input  logic [N_SLAVES-1:0]                  s_ACK,
   input  logic [N_SLAVES-1:0]                  s_ERR
);
   localparam int AW = WB_ADDR_WIDTH;
   localparam int DW = WB_DATA_WIDTH;
   localparam int SW = DW / 8;
   localparam int NT = N_SLAVES + 1;
   localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int TW = $clog2(NT);
   localparam int WDW = $clog2(TIMEOUT + 2);
   localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} arb_state_t;

   logic [TW-1:0] req_tgt [N_MASTERS];
   logic [NT-1:0] owned;
   logic [MW-1:0] owner [NT];
   logic [NT-1:0] tgt_ack;
   logic [NT-1:0] tgt_err;
   logic [DW-1:0] tgt_dat [NT];

   genvar gi;

   // A master that owns a target keeps routing there; otherwise its address is decoded.
   for (gi = 0; gi < N_MASTERS; gi++) begin : g_mst
      logic          own_any, ack_j, err_j;
      logic [TW-1:0] own_t, dec;
      logic [DW-1:0] dat_j;

      always_comb begin
         own_any = 1'b0;
         own_t = '0;
         ack_j = 1'b0;
         err_j = 1'b0;
         dat_j = '0;
         for (int t = 0; t < NT; t++) begin
            if (owned[t] && owner[t] == MW'(gi)) begin
               own_any = 1'b1;
               own_t = TW'(t);
               ack_j = tgt_ack[t];
               err_j = tgt_err[t];
               dat_j = tgt_dat[t];
            end
         end
         dec = TW'(N_SLAVES);
         for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (m_ADR[gi*AW +: AW] >= SLAVE_ADDR_BASE[i*AW +: AW] &&
                m_ADR[gi*AW +: AW] <= SLAVE_ADDR_LIMIT[i*AW +: AW])
               dec = TW'(i);
         end
      end

      assign req_tgt[gi] = own_any ? own_t : dec;
      assign m_ACK[gi] = ack_j;
      assign m_ERR[gi] = err_j;
      assign m_DAT_R[gi*DW +: DW] = dat_j;
   end

   for (gi = 0; gi < NT; gi++) begin : g_tgt
      arb_state_t     state_reg, state_next;
      logic [MW-1:0]  owner_reg, prio_reg, win;
      logic [WDW-1:0] wd_cnt_reg, wd_cnt_next;
      logic           any_req, act, grant, owner_cyc, owner_stb, wd_hit, rsp_ack, rsp_err;

      always_ff @(posedge clk) begin
         if (rst) state_reg <= IDLE;
         else     state_reg <= state_next;
      end

      always_comb begin
         state_next = state_reg;
         case (state_reg)
            IDLE:    if (any_req) state_next = OWNED;
            OWNED:   if (!owner_cyc) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end

      always_comb begin
         act = (state_reg == OWNED) && !rst;
         grant = (state_reg == IDLE) && any_req;
      end

      // Search starts at prio_reg, the master after the previous winner.
      always_comb begin
         int idx;
         any_req = 1'b0;
         win = '0;
         idx = 0;
         for (int k = 0; k < N_MASTERS; k++) begin
            idx = int'(prio_reg) + k;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (!any_req && m_CYC[idx] && m_STB[idx] && req_tgt[idx] == TW'(gi)) begin
               any_req = 1'b1;
               win = MW'(idx);
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            owner_reg <= '0;
            prio_reg <= '0;
         end else if (grant) begin
            owner_reg <= win;
            prio_reg <= (win == MW'(N_MASTERS - 1)) ? '0 : win + 1'b1;
         end
      end

      assign owner_cyc = m_CYC[owner_reg];
      assign owner_stb = m_STB[owner_reg];

      // Expiry is decided from the registered count alone, so the gated STB never depends on ACK.
      assign wd_hit = (TIMEOUT > 0) && act && owner_stb && (wd_cnt_reg == WD_LAST);

      always_comb begin
         if (TIMEOUT == 0 || !act || !owner_stb || rsp_ack || rsp_err || wd_hit)
            wd_cnt_next = '0;
         else
            wd_cnt_next = wd_cnt_reg + 1'b1;
      end

      always_ff @(posedge clk) begin
         if (rst) wd_cnt_reg <= '0;
         else     wd_cnt_reg <= wd_cnt_next;
      end

      assign owned[gi] = act;
      assign owner[gi] = owner_reg;
      assign tgt_ack[gi] = rsp_ack;
      assign tgt_err[gi] = rsp_err | (wd_hit & ~rsp_ack);

      if (gi < N_SLAVES) begin : g_ext
         assign rsp_ack = s_ACK[gi];
         assign rsp_err = s_ERR[gi];
         assign tgt_dat[gi] = s_DAT_R[gi*DW +: DW];
         assign s_CYC[gi] = act & owner_cyc;
         assign s_STB[gi] = act & owner_stb & ~wd_hit;
         assign s_WE[gi] = act & m_WE[owner_reg];
         assign s_ADR[gi*AW +: AW] = act ? m_ADR[owner_reg*AW +: AW] : '0;
         assign s_DAT_W[gi*DW +: DW] = act ? m_DAT_W[owner_reg*DW +: DW] : '0;
         assign s_SEL[gi*SW +: SW] = act ? m_SEL[owner_reg*SW +: SW] : '0;
         assign s_CTI[gi*3 +: 3] = act ? m_CTI[owner_reg*3 +: 3] : '0;
         assign s_BTE[gi*2 +: 2] = act ? m_BTE[owner_reg*2 +: 2] : '0;
      end else begin : g_dec_err
         logic err_reg;
         always_ff @(posedge clk) begin
            if (rst || !act) err_reg <= 1'b0;
            else             err_reg <= owner_stb & ~err_reg;
         end
         assign rsp_ack = 1'b0;
         assign rsp_err = err_reg;
         assign tgt_dat[gi] = '0;
      end
   end
endmodule

// File: tb/tb_wb_interconnect_nxm.sv
// Scoreboard bench for wb_interconnect_nxm: 3 masters, 2 slaves (slave0 acks, slave1 silent),
// covering arbitration order, latency, decode error, watchdog, burst lock and reset abort.
module tb_wb_interconnect_nxm;
   localparam int NM = 3;
   localparam int NS = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NM*32-1:0] m_ADR = '0, m_DAT_W = '0, m_DAT_R;
   logic [NM*4-1:0]  m_SEL = '0;
   logic [NM*3-1:0]  m_CTI = '0;
   logic [NM*2-1:0]  m_BTE = '0;
   logic [NM-1:0]    m_CYC = '0, m_STB = '0, m_WE = '0, m_ACK, m_ERR;
   logic [NS*32-1:0] s_ADR, s_DAT_W, s_DAT_R;
   logic [NS*4-1:0]  s_SEL;
   logic [NS*3-1:0]  s_CTI;
   logic [NS*2-1:0]  s_BTE;
   logic [NS-1:0]    s_CYC, s_STB, s_WE, s_ACK, s_ERR;

   wb_interconnect_nxm #(
      .N_MASTERS(NM), .N_SLAVES(NS), .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32),
      .SLAVE_ADDR_BASE({32'h0000_1000, 32'h0000_0000}),
      .SLAVE_ADDR_LIMIT({32'h0000_1FFF, 32'h0000_0FFF}),
      .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .m_ADR(m_ADR), .m_DAT_W(m_DAT_W), .m_SEL(m_SEL), .m_CTI(m_CTI), .m_BTE(m_BTE),
      .m_CYC(m_CYC), .m_STB(m_STB), .m_WE(m_WE),
      .m_DAT_R(m_DAT_R), .m_ACK(m_ACK), .m_ERR(m_ERR),
      .s_ADR(s_ADR), .s_DAT_W(s_DAT_W), .s_SEL(s_SEL), .s_CTI(s_CTI), .s_BTE(s_BTE),
      .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE),
      .s_DAT_R(s_DAT_R), .s_ACK(s_ACK), .s_ERR(s_ERR)
   );

   always #5 clk = ~clk;

   // Slave 0 acks the cycle after it sees STB; slave 1 never responds.
   logic ack0_q = 1'b0;
   always @(posedge clk) ack0_q <= !rst && s_STB[0] && !ack0_q;
   assign s_ACK = {1'b0, ack0_q};
   assign s_ERR = 2'b00;
   assign s_DAT_R = {32'h0, ack0_q ? 32'hCAFE_F00D : 32'h0};

   typedef struct {
      int          m;
      logic        err;
      logic [31:0] dat;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_run = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   stb_any = 0;
   int   stb1_cnt = 0;
   logic stb1_at_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_run++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, expv);
      end
   endtask

   function automatic exp_t mk(input int m, input logic err, input logic [31:0] dat);
      exp_t x;
      x.m = m;
      x.err = err;
      x.dat = dat;
      return x;
   endfunction

   always @(negedge clk) begin
      if (s_STB != '0) stb_any++;
      if (s_STB[1]) stb1_cnt++;
      for (int j = 0; j < NM; j++) begin
         if (m_ACK[j] | m_ERR[j]) begin
            $display("[TB] cyc %0d m%0d ack=%0b err=%0b dat=%h", cyc, j, m_ACK[j], m_ERR[j],
                     m_DAT_R[j*32 +: 32]);
            if (m_ERR[j]) stb1_at_err = s_STB[1];
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", {30'h0, m_ACK[j], m_ERR[j]}, 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_master", j, e.m);
               chk("rsp_err", {31'h0, m_ERR[j]}, {31'h0, e.err});
               chk("rsp_ack", {31'h0, m_ACK[j]}, {31'h0, ~e.err});
               chk("rsp_data", m_DAT_R[j*32 +: 32], e.dat);
            end
         end
      end
   end

   // One CYC of 'beats' beats; beats after the first use adr_later, which must not reroute.
   task automatic access(input int j, input logic [31:0] adr, input logic [31:0] adr_later,
                         input int beats, output int t_last);
      bit ok;
      t_last = 0;
      @(posedge clk); #1;
      m_ADR[j*32 +: 32] = adr;
      m_SEL[j*4 +: 4] = 4'hF;
      m_CYC[j] = 1'b1;
      m_STB[j] = 1'b1;
      for (int b = 0; b < beats; b++) begin
         ok = 1'b0;
         for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (m_ACK[j] | m_ERR[j]) ok = 1'b1;
         end
         if (!ok) chk("access_wait", {31'h0, m_ACK[j] | m_ERR[j]}, 32'h1);
         t_last = cyc;
         @(posedge clk); #1;
         m_ADR[j*32 +: 32] = adr_later;
      end
      m_CYC[j] = 1'b0;
      m_STB[j] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int t0, t1, t2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_stb", {30'h0, s_STB}, 32'h0);
      chk("rst_s_cyc", {30'h0, s_CYC}, 32'h0);
      chk("rst_s_adr0", s_ADR[31:0], 32'h0);
      chk("rst_m_resp", {26'h0, m_ACK, m_ERR}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Three simultaneous requesters, then master 0 alone, then all three again.
      exp_q.push_back(mk(0, 1'b0, 32'hCAFE_F00D));
      exp_q.push_back(mk(1, 1'b0, 32'hCAFE_F00D));
      exp_q.push_back(mk(2, 1'b0, 32'hCAFE_F00D));
      fork
         access(0, 32'h100, 32'h100, 1, t0);
         access(1, 32'h200, 32'h200, 1, t1);
         access(2, 32'h300, 32'h300, 1, t2);
      join
      chk("rr1_gap01", t1 - t0, 4);
      chk("rr1_gap12", t2 - t1, 4);
      exp_q.push_back(mk(0, 1'b0, 32'hCAFE_F00D));
      access(0, 32'h100, 32'h100, 1, t0);
      exp_q.push_back(mk(1, 1'b0, 32'hCAFE_F00D));
      exp_q.push_back(mk(2, 1'b0, 32'hCAFE_F00D));
      exp_q.push_back(mk(0, 1'b0, 32'hCAFE_F00D));
      fork
         access(0, 32'h100, 32'h100, 1, t0);
         access(1, 32'h200, 32'h200, 1, t1);
         access(2, 32'h300, 32'h300, 1, t2);
      join
      chk("rr3_gap12", t2 - t1, 4);
      chk("rr3_gap20", t0 - t2, 4);

      // Latency: request in T, slave STB in T+1, ACK passed through in T+2.
      @(posedge clk); #1;
      m_ADR[63:32] = 32'h10;
      m_CYC[1] = 1'b1;
      m_STB[1] = 1'b1;
      exp_q.push_back(mk(1, 1'b0, 32'hCAFE_F00D));
      @(negedge clk);
      chk("lat_T_stb0", {31'h0, s_STB[0]}, 32'h0);
      @(negedge clk);
      chk("lat_T1_stb0", {31'h0, s_STB[0]}, 32'h1);
      chk("lat_T1_adr0", s_ADR[31:0], 32'h10);
      chk("lat_T1_cyc1", {31'h0, s_CYC[1]}, 32'h0);
      @(negedge clk);
      chk("lat_T2_ack1", {31'h0, m_ACK[1]}, 32'h1);
      chk("lat_T2_dat0", m_DAT_R[31:0], 32'h0);
      @(posedge clk); #1;
      m_CYC[1] = 1'b0;
      m_STB[1] = 1'b0;

      // Unmapped address goes to the decode-error target.
      stb_any = 0;
      exp_q.push_back(mk(2, 1'b1, 32'h0));
      access(2, 32'hFFFF_0000, 32'hFFFF_0000, 1, t2);
      repeat (2) @(negedge clk);
      chk("decerr_no_stb", stb_any, 0);

      // Watchdog on the silent slave.
      stb1_cnt = 0;
      exp_q.push_back(mk(0, 1'b1, 32'h0));
      access(0, 32'h1000, 32'h1000, 1, t0);
      chk("wd_stb_cycles", stb1_cnt, 7);
      chk("wd_stb_at_err", {31'h0, stb1_at_err}, 32'h0);

      // Locked 4-beat burst; later beats carry an unmapped address yet stay on slave 0.
      for (int b = 0; b < 4; b++) exp_q.push_back(mk(0, 1'b0, 32'hCAFE_F00D));
      exp_q.push_back(mk(1, 1'b0, 32'hCAFE_F00D));
      fork
         access(0, 32'h40, 32'hFFFF_0000, 4, t0);
         begin
            @(posedge clk);
            access(1, 32'h80, 32'h80, 1, t1);
         end
      join
      chk("burst_lock_gap", t1 - t0, 4);

      // Reset in the middle of a transfer to the silent slave.
      @(posedge clk); #1;
      m_ADR[31:0] = 32'h1000;
      m_CYC[0] = 1'b1;
      m_STB[0] = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_rst_stb1", {31'h0, s_STB[1]}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_s_stb", {30'h0, s_STB}, 32'h0);
      chk("mid_rst_s_adr1", s_ADR[63:32], 32'h0);
      chk("mid_rst_m_resp", {26'h0, m_ACK, m_ERR}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_CYC[0] = 1'b0;
      m_STB[0] = 1'b0;
      @(negedge clk);
      chk("post_rst_s_cyc", {30'h0, s_CYC}, 32'h0);
      chk("post_rst_s_stb", {30'h0, s_STB}, 32'h0);
      exp_q.push_back(mk(2, 1'b0, 32'hCAFE_F00D));
      access(2, 32'h20, 32'h20, 1, t2);

      repeat (3) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
